// File: rtl/instruction_fetch.sv
// IF stage with IF/ID register: owns PCF, keeps one fetch outstanding, and applies
// decode stall/flush and execute redirects so decode only sees correct-path words.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemValid,
  input  logic [31:0] ImemRdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  typedef enum logic [1:0] {S_BOOT, S_REQ, S_HOLD, S_DROP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_pcf;
  logic [31:0] r_req_addr;
  logic [31:0] r_hold_instr;
  logic [31:0] w_target;
  logic [31:0] w_req_plus4;
  logic        w_accept;
  logic [31:0] w_acc_instr;

  assign w_target    = PCTargetE & ~32'd3;
  assign w_req_plus4 = r_req_addr + 32'd4;
  assign ImemAddr    = r_req_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_BOOT;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_BOOT: w_next = S_REQ;
      S_REQ: begin
        if (PCSrcE)                  w_next = ImemValid ? S_REQ : S_DROP;
        else if (ImemValid && StallD) w_next = S_HOLD;
      end
      S_HOLD: if (PCSrcE || !StallD) w_next = S_REQ;
      S_DROP: if (ImemValid) w_next = S_REQ;
      default: w_next = S_BOOT;
    endcase
  end

  always_comb begin
    ImemReq     = 1'b0;
    w_accept    = 1'b0;
    w_acc_instr = ImemRdata;
    case (r_state)
      S_REQ: begin
        ImemReq  = 1'b1;
        w_accept = ImemValid && !PCSrcE && !StallD;
      end
      S_HOLD: begin
        w_accept    = !PCSrcE && !StallD;
        w_acc_instr = r_hold_instr;
      end
      S_DROP:  ImemReq = 1'b1;
      default: ImemReq = 1'b0;
    endcase
  end

  // While parked in HOLD, r_req_addr still names the held word; r_pcf already points past it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcf      <= RESET_PC;
      r_req_addr <= RESET_PC;
    end else if (PCSrcE) begin
      r_pcf <= w_target;
      if (!(ImemReq && !ImemValid)) r_req_addr <= w_target;
    end else begin
      case (r_state)
        S_BOOT: r_req_addr <= r_pcf;
        S_REQ: begin
          if (ImemValid) begin
            r_pcf <= w_req_plus4;
            if (!StallD) r_req_addr <= w_req_plus4;
          end
        end
        S_HOLD:  if (!StallD) r_req_addr <= r_pcf;
        S_DROP:  if (ImemValid) r_req_addr <= r_pcf;
        default: r_req_addr <= r_req_addr;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_REQ && ImemValid && !PCSrcE && StallD) r_hold_instr <= ImemRdata;
  end

  // IF/ID register: flush beats stall beats accept; anything else is a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      InstrD   <= NOP_INSTR;
      PCD      <= 32'd0;
      PCPlus4D <= 32'd0;
      ValidD   <= 1'b0;
    end else if (FlushD) begin
      InstrD   <= NOP_INSTR;
      PCD      <= 32'd0;
      PCPlus4D <= 32'd0;
      ValidD   <= 1'b0;
    end else if (!StallD) begin
      if (w_accept) begin
        InstrD   <= w_acc_instr;
        PCD      <= r_req_addr;
        PCPlus4D <= w_req_plus4;
        ValidD   <= 1'b1;
      end else begin
        InstrD   <= NOP_INSTR;
        PCD      <= 32'd0;
        PCPlus4D <= 32'd0;
        ValidD   <= 1'b0;
      end
    end
  end

endmodule
